// File: rtl/prbs9_rx_checker.sv
// PRBS9 receive checker: slices the downsampled sample to a hard bit, self-synchronizes
// a local x^9+x^5+1 LFSR from the received stream, then counts bits and errors while locked.
module prbs9_rx_checker #(
    parameter int unsigned NB_INPUT   = 12,
    parameter int unsigned NB_COUNTER = 2,
    parameter int unsigned NB_REG     = 9,
    parameter int unsigned ACQ_LEN    = 16,
    parameter int unsigned WINDOW_LEN = 64,
    parameter int unsigned MAX_ERRORS = 4,
    parameter int unsigned NB_COUNT   = 32
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic [NB_INPUT-1:0]   i_data,
    input  logic [NB_COUNTER-1:0] i_enable,
    input  logic                  i_EnbRx,
    output logic                  o_out_bit,
    output logic                  o_lock,
    output logic                  o_led,
    output logic [NB_COUNT-1:0]   o_bit_count,
    output logic [NB_COUNT-1:0]   o_err_count
);

    localparam int unsigned MW = $clog2(ACQ_LEN + 1);
    localparam int unsigned WW = $clog2(WINDOW_LEN + 1);

    localparam logic [3:0]    LoadLast = 4'(NB_REG - 1);
    localparam logic [MW-1:0] AcqLast  = MW'(ACQ_LEN - 1);
    localparam logic [WW-1:0] WinLen   = WW'(WINDOW_LEN);
    localparam logic [WW-1:0] MaxErr   = WW'(MAX_ERRORS);

    typedef enum logic [1:0] {StLoad, StAcquire, StLocked} state_e;

    state_e              state_q, state_d;
    logic [NB_REG-1:0]   r_q, r_d;
    logic [3:0]          load_q, load_d;
    logic [MW-1:0]       match_q, match_d;
    logic [WW-1:0]       win_q, win_d;
    logic [WW-1:0]       win_err_q, win_err_d;
    logic [NB_COUNT-1:0] bit_cnt_q, bit_cnt_d;
    logic [NB_COUNT-1:0] err_cnt_q, err_cnt_d;
    logic                out_bit_q, out_bit_d;
    logic                lock_q;

    logic                stb;
    logic                rx_bit;
    logic                pred;
    logic                bit_err;
    logic [NB_REG-1:0]   r_shift;
    logic [WW-1:0]       win_nx;
    logic [WW-1:0]       win_err_nx;

    // Only the sign bit drives the slicer.
    logic unused_data;
    assign unused_data = ^i_data[NB_INPUT-2:0];

    assign stb     = (i_enable == '0) && i_EnbRx;
    assign rx_bit  = ~i_data[NB_INPUT-1];
    assign pred    = r_q[NB_REG-1] ^ r_q[4];
    assign bit_err = rx_bit ^ pred;
    assign r_shift = {r_q[NB_REG-2:0], rx_bit};

    // Next-state logic for the sync FSM, LFSR, window and counters.
    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        load_d     = load_q;
        match_d    = match_q;
        win_d      = win_q;
        win_err_d  = win_err_q;
        bit_cnt_d  = bit_cnt_q;
        err_cnt_d  = err_cnt_q;
        out_bit_d  = out_bit_q;
        win_nx     = win_q + 1'b1;
        win_err_nx = win_err_q + {{(WW-1){1'b0}}, bit_err};

        if (!i_EnbRx) begin
            state_d = StLoad;
            load_d  = '0;
            match_d = '0;
        end else if (stb) begin
            out_bit_d = rx_bit;
            case (state_q)
                StLoad: begin
                    r_d = r_shift;
                    if (load_q == LoadLast) begin
                        state_d = StAcquire;
                        load_d  = '0;
                        match_d = '0;
                    end else begin
                        load_d = load_q + 1'b1;
                    end
                end
                StAcquire: begin
                    r_d = r_shift;
                    if (bit_err || (r_shift == '0)) begin
                        // All-zero register would self-predict zeros forever: reject it.
                        state_d = StLoad;
                        load_d  = '0;
                        match_d = '0;
                    end else if (match_q == AcqLast) begin
                        state_d   = StLocked;
                        match_d   = '0;
                        bit_cnt_d = '0;
                        err_cnt_d = '0;
                        win_d     = '0;
                        win_err_d = '0;
                    end else begin
                        match_d = match_q + 1'b1;
                    end
                end
                StLocked: begin
                    r_d = {r_q[NB_REG-2:0], pred};
                    if (bit_cnt_q != '1) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                    if (bit_err && (err_cnt_q != '1)) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                    if (win_nx == WinLen) begin
                        // The closing bit's error already sits in win_err_nx.
                        win_d     = '0;
                        win_err_d = '0;
                        if (win_err_nx > MaxErr) begin
                            state_d = StLoad;
                            load_d  = '0;
                        end
                    end else begin
                        win_d     = win_nx;
                        win_err_d = win_err_nx;
                    end
                end
                default: begin
                    state_d = StLoad;
                    load_d  = '0;
                    match_d = '0;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= StLoad;
            r_q       <= '0;
            load_q    <= '0;
            match_q   <= '0;
            win_q     <= '0;
            win_err_q <= '0;
            bit_cnt_q <= '0;
            err_cnt_q <= '0;
            out_bit_q <= 1'b0;
            lock_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            load_q    <= load_d;
            match_q   <= match_d;
            win_q     <= win_d;
            win_err_q <= win_err_d;
            bit_cnt_q <= bit_cnt_d;
            err_cnt_q <= err_cnt_d;
            out_bit_q <= out_bit_d;
            lock_q    <= (state_d == StLocked);
        end
    end

    assign o_out_bit   = out_bit_q;
    assign o_lock      = lock_q;
    assign o_led       = lock_q;
    assign o_bit_count = bit_cnt_q;
    assign o_err_count = err_cnt_q;

endmodule

// File: tb/tb_prbs9_rx_checker.sv
// Bench for prbs9_rx_checker: a stream-level model checked every cycle plus directed
// literal checks for lock timing, error counting, lock loss, gating and reset.
module tb_prbs9_rx_checker;

    localparam int ACQ_LEN    = 16;
    localparam int WINDOW_LEN = 64;
    localparam int MAX_ERRORS = 4;

    logic        clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [11:0] i_data = '0;
    logic [1:0]  i_enable = '0;
    logic        i_EnbRx = 1'b0;
    logic        o_out_bit;
    logic        o_lock;
    logic        o_led;
    logic [31:0] o_bit_count;
    logic [31:0] o_err_count;

    int errors = 0;
    int checks = 0;

    bit prbs [4096];
    int sidx = 0;
    int lock_seen;

    // Model state: mode 0 = load, 1 = acquire, 2 = locked.
    int     m_mode, m_load, m_match, m_win, m_werr;
    longint m_bits, m_errs;
    bit     m_out;
    int     q[$];

    prbs9_rx_checker dut (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_data     (i_data),
        .i_enable   (i_enable),
        .i_EnbRx    (i_EnbRx),
        .o_out_bit  (o_out_bit),
        .o_lock     (o_lock),
        .o_led      (o_led),
        .o_bit_count(o_bit_count),
        .o_err_count(o_err_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: q holds the last nine register bits, oldest first.
    always @(posedge clk or negedge i_rst) begin
        bit rx, pred;
        if (!i_rst) begin
            m_mode = 0; m_load = 0; m_match = 0; m_win = 0; m_werr = 0;
            m_bits = 0; m_errs = 0; m_out = 1'b0;
            q = {0, 0, 0, 0, 0, 0, 0, 0, 0};
        end else if (!i_EnbRx) begin
            m_mode = 0; m_load = 0; m_match = 0;
        end else if (i_enable == 2'd0) begin
            rx    = ~i_data[11];
            pred  = bit'(q[0] ^ q[4]);
            m_out = rx;
            if (m_mode == 0) begin
                q.push_back(int'(rx)); void'(q.pop_front());
                m_load++;
                if (m_load == 9) begin m_mode = 1; m_load = 0; m_match = 0; end
            end else if (m_mode == 1) begin
                q.push_back(int'(rx)); void'(q.pop_front());
                if (rx != pred || q.sum() == 0) begin
                    m_mode = 0; m_load = 0; m_match = 0;
                end else begin
                    m_match++;
                    if (m_match == ACQ_LEN) begin
                        m_mode = 2; m_match = 0;
                        m_bits = 0; m_errs = 0; m_win = 0; m_werr = 0;
                    end
                end
            end else begin
                q.push_back(int'(pred)); void'(q.pop_front());
                if (m_bits < 64'hFFFF_FFFF) m_bits++;
                if (rx != pred) begin
                    m_werr++;
                    if (m_errs < 64'hFFFF_FFFF) m_errs++;
                end
                m_win++;
                if (m_win == WINDOW_LEN) begin
                    if (m_werr > MAX_ERRORS) begin m_mode = 0; m_load = 0; end
                    m_win = 0; m_werr = 0;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        checks++;
        if (o_lock !== (m_mode == 2) || o_led !== (m_mode == 2) || o_out_bit !== m_out ||
            o_bit_count !== 32'(m_bits) || o_err_count !== 32'(m_errs)) begin
            errors++;
            $display("FAIL model_cmp t=%0t lock=%0b/%0b led=%0b out=%0b/%0b bits=%0d/%0d errs=%0d/%0d",
                     $time, o_lock, (m_mode == 2), o_led, o_out_bit, m_out,
                     o_bit_count, m_bits, o_err_count, m_errs);
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [11:0] d, input logic [1:0] e, input logic en);
        @(negedge clk);
        i_data   = d;
        i_enable = e;
        i_EnbRx  = en;
    endtask

    // One symbol period: strobe sample then three junk samples with i_enable != 0.
    task automatic sym(input bit b);
        cyc(b ? 12'h1A0 : 12'hE60, 2'd0, 1'b1);
        for (int k = 1; k < 4; k++) cyc(12'($urandom), 2'(k), 1'b1);
    endtask

    task automatic prbs_syms(input int n, input int inv);
        for (int i = 0; i < n; i++) begin
            sym(prbs[sidx] ^ (i < inv));
            sidx++;
        end
    endtask

    initial begin
        for (int i = 0; i < 9; i++) prbs[i] = 1'b1;
        for (int i = 9; i < 4096; i++) prbs[i] = prbs[i-9] ^ prbs[i-5];

        // Reset held with random inputs.
        for (int i = 0; i < 6; i++) cyc(12'($urandom), 2'($urandom), 1'($urandom));
        chk("rst_lock", o_lock, 0);
        chk("rst_led", o_led, 0);
        chk("rst_out", o_out_bit, 0);
        chk("rst_bits", o_bit_count, 0);
        chk("rst_errs", o_err_count, 0);

        // Released but receiver disabled: nothing moves.
        @(negedge clk);
        i_rst = 1'b1;
        for (int i = 0; i < 8; i++) cyc(12'($urandom), 2'(i), 1'b0);
        chk("dis_out", o_out_bit, 0);
        chk("dis_lock", o_lock, 0);
        chk("dis_bits", o_bit_count, 0);

        // Clean lock: 9 load + 16 matching strobes.
        prbs_syms(24, 0);
        chk("lock_after_24", o_lock, 0);
        prbs_syms(1, 0);
        chk("lock_after_25", o_lock, 1);
        chk("led_after_25", o_led, 1);
        chk("bits_at_lock", o_bit_count, 0);
        prbs_syms(1000, 0);
        chk("bits_1000", o_bit_count, 1000);
        chk("errs_clean", o_err_count, 0);
        chk("out_bit", o_out_bit, prbs[sidx-1]);

        // Three isolated errors stay under the window threshold.
        prbs_syms(3, 3);
        prbs_syms(100, 0);
        chk("iso_errs", o_err_count, 3);
        chk("iso_lock", o_lock, 1);
        chk("iso_bits", o_bit_count, 1103);

        // Five errors in the window ending at locked bit 1152 (window position now 15).
        prbs_syms(48, 5);
        chk("burst_before_close", o_lock, 1);
        prbs_syms(1, 0);
        chk("burst_lock_lost", o_lock, 0);
        chk("burst_errs", o_err_count, 8);
        chk("burst_bits", o_bit_count, 1152);
        prbs_syms(24, 0);
        chk("relock_24", o_lock, 0);
        chk("held_errs", o_err_count, 8);
        prbs_syms(1, 0);
        chk("relock_25", o_lock, 1);
        chk("relock_bits", o_bit_count, 0);
        chk("relock_errs", o_err_count, 0);

        // Samples without a strobe phase are ignored.
        prbs_syms(10, 0);
        for (int i = 0; i < 12; i++) cyc(12'($urandom), 2'(1 + (i % 3)), 1'b1);
        chk("gate_bits", o_bit_count, 10);
        chk("gate_out", o_out_bit, prbs[sidx-1]);

        // Disable mid-lock.
        cyc(12'($urandom), 2'd0, 1'b0);
        @(negedge clk);
        chk("disable_lock", o_lock, 0);
        for (int i = 0; i < 20; i++) cyc(12'($urandom), 2'(i), 1'b0);
        chk("disable_bits", o_bit_count, 10);
        chk("disable_out", o_out_bit, prbs[sidx-1]);
        prbs_syms(24, 0);
        chk("enable_relock_24", o_lock, 0);
        prbs_syms(1, 0);
        chk("enable_relock_25", o_lock, 1);

        // Asynchronous reset mid-operation.
        prbs_syms(30, 0);
        chk("pre_reset_bits", o_bit_count, 30);
        @(negedge clk);
        #2 i_rst = 1'b0;
        #1;
        chk("mid_rst_bits", o_bit_count, 0);
        chk("mid_rst_lock", o_lock, 0);
        chk("mid_rst_out", o_out_bit, 0);
        for (int i = 0; i < 3; i++) cyc(12'($urandom), 2'($urandom), 1'b1);
        @(negedge clk);
        i_rst = 1'b1;

        // Constant inputs must never lock.
        lock_seen = 0;
        for (int i = 0; i < 200; i++) begin
            sym(1'b0);
            if (o_lock) lock_seen++;
        end
        chk("const_neg_no_lock", lock_seen, 0);
        lock_seen = 0;
        for (int i = 0; i < 200; i++) begin
            sym(1'b1);
            if (o_lock) lock_seen++;
        end
        chk("const_pos_no_lock", lock_seen, 0);
        chk("const_bits", o_bit_count, 0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
